// File: rtl/ws2812_pkg.sv
// Shared types and elaboration-time helpers for the WS2812 chain driver.
// Converts nanosecond/microsecond timings into whole clock cycles.
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } state_e;

  localparam int ORDER_GRB = 0;
  localparam int ORDER_RGB = 1;

  // Whole-MHz clock rate is used deliberately so every timing truncates the same way.
  function automatic int cyc_from_ns(input int clk_fre, input int ns);
    int c;
    c = (clk_fre / 1_000_000) * ns / 1000;
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int cyc_from_us(input int clk_fre, input int us);
    return (clk_fre / 1_000_000) * us;
  endfunction

  // Colour RAM holds {R,G,B}; the wire order is chosen at elaboration.
  function automatic logic [23:0] reorder(input logic [23:0] c, input int order);
    case (order)
      ORDER_RGB: return c;
      ORDER_GRB: return {c[15:8], c[23:16], c[7:0]};
      default:   return {c[15:8], c[23:16], c[7:0]};
    endcase
  endfunction

endpackage

// File: rtl/ws2812_color_ram.sv
// Per-LED colour storage: synchronous write, one-cycle registered read.
// Contents survive reset; entries never written read back as zero.
module ws2812_color_ram #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rd_q = '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/ws2812_chain.sv
// WS2812 strip driver: streams NUM_LEDS colours from the colour RAM onto one
// registered data line, then holds the line low for the latch period.
module ws2812_chain
  import ws2812_pkg::*;
#(
  parameter int CLK_FRE      = 32_940_000,
  parameter int NUM_LEDS     = 8,
  parameter int T0H_NS       = 400,
  parameter int T0L_NS       = 850,
  parameter int T1H_NS       = 850,
  parameter int T1L_NS       = 400,
  parameter int RESET_US     = 80,
  parameter int COLOR_ORDER  = 0,
  parameter int AUTO_REFRESH = 1,
  parameter int ADDR_W       = $clog2((NUM_LEDS > 2) ? NUM_LEDS : 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_color,
  input  logic              update,
  output logic              busy,
  output logic              frame_done,
  output logic              data
);

  localparam int C0H     = cyc_from_ns(CLK_FRE, T0H_NS);
  localparam int C0L     = cyc_from_ns(CLK_FRE, T0L_NS);
  localparam int C1H     = cyc_from_ns(CLK_FRE, T1H_NS);
  localparam int C1L     = cyc_from_ns(CLK_FRE, T1L_NS);
  localparam int LATCH_C = cyc_from_us(CLK_FRE, RESET_US);
  localparam int M01     = (C0H > C0L) ? C0H : C0L;
  localparam int M23     = (C1H > C1L) ? C1H : C1L;
  localparam int M03     = (M01 > M23) ? M01 : M23;
  localparam int CNT_MAX = (M03 > LATCH_C) ? M03 : LATCH_C;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [ADDR_W:0]   LEDS_W   = (ADDR_W + 1)'(NUM_LEDS);
  localparam logic [ADDR_W-1:0] LAST_LED = ADDR_W'(NUM_LEDS - 1);

  function automatic logic [CNT_W-1:0] hi_len(input logic b);
    return b ? CNT_W'(C1H - 1) : CNT_W'(C0H - 1);
  endfunction

  function automatic logic [CNT_W-1:0] lo_len(input logic b);
    return b ? CNT_W'(C1L - 1) : CNT_W'(C0L - 1);
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        bit_q, bit_d;
  logic [ADDR_W-1:0] led_q, led_d;
  logic [23:0]       shift_q, shift_d;
  logic              dirty_q, dirty_d;
  logic              pending_q, pending_d;
  logic              done_d;
  logic              data_q, busy_q, done_q;
  logic              wr_ok, start;
  logic [23:0]       rd_data, word;
  logic [ADDR_W-1:0] rd_addr;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < LEDS_W);

  // Read address runs one LED ahead so the next word is ready at the final LOW cycle.
  assign rd_addr = (state_q == ST_IDLE || state_q == ST_LATCH || led_q == LAST_LED)
                   ? '0 : led_q + 1'b1;

  ws2812_color_ram #(
    .DEPTH (NUM_LEDS),
    .DATA_W(24),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_ok),
    .wr_addr(wr_addr),
    .wr_data(wr_color),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    led_d     = led_q;
    shift_d   = shift_q;
    pending_d = pending_q;
    dirty_d   = dirty_q || wr_ok;
    done_d    = 1'b0;
    start     = 1'b0;
    word      = reorder(rd_data, COLOR_ORDER);
    case (state_q)
      ST_IDLE: begin
        if (update || pending_q || ((AUTO_REFRESH != 0) && dirty_q)) begin
          start   = 1'b1;
          state_d = ST_LOAD;
          led_d   = '0;
        end
      end
      ST_LOAD: begin
        shift_d = word;
        bit_d   = '0;
        cnt_d   = hi_len(word[23]);
        state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          cnt_d   = lo_len(shift_q[23]);
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (bit_q != 5'd23) begin
          shift_d = {shift_q[22:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          cnt_d   = hi_len(shift_q[22]);
          state_d = ST_HIGH;
        end else if (led_q != LAST_LED) begin
          shift_d = word;
          bit_d   = '0;
          led_d   = led_q + 1'b1;
          cnt_d   = hi_len(word[23]);
          state_d = ST_HIGH;
        end else begin
          cnt_d   = CNT_W'(LATCH_C - 1);
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (update && state_q != ST_IDLE) pending_d = 1'b1;
    // A write landing in the start cycle keeps the RAM dirty for the following frame.
    if (start) begin
      pending_d = 1'b0;
      dirty_d   = wr_ok;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      led_q     <= '0;
      dirty_q   <= 1'b1;
      pending_q <= 1'b0;
      data_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      led_q     <= led_d;
      dirty_q   <= dirty_d;
      pending_q <= pending_d;
      data_q    <= (state_d == ST_HIGH);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign data       = data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_ws2812_chain.sv
// Directed bench for a 3-LED, 32 MHz, GRB-order, auto-refresh chain: decodes
// every frame from the data line and compares it to hand-computed words.
module tb_ws2812_chain;

  localparam int HI1   = 27;
  localparam int LO1   = 12;
  localparam int HI0   = 12;
  localparam int LO0   = 27;
  localparam int LATCH = 2560;
  localparam int BITS  = 72;
  localparam int FRAME = 1 + BITS * 39 + LATCH;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [23:0] wr_color = '0;
  logic        update = 1'b0;
  logic        busy, frame_done, data;

  int total = 0;
  int bad = 0;
  int fd_cnt = 0;

  ws2812_chain #(
    .CLK_FRE     (32_000_000),
    .NUM_LEDS    (3),
    .COLOR_ORDER (0),
    .AUTO_REFRESH(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_color  (wr_color),
    .update    (update),
    .busy      (busy),
    .frame_done(frame_done),
    .data      (data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] classify(input int h, input int l);
    if (h == HI1 && l == LO1) return 2'b01;
    if (h == HI0 && l == LO0) return 2'b00;
    return 2'b10;
  endfunction

  task automatic wr(input logic [1:0] a, input logic [23:0] c);
    wr_en    = 1'b1;
    wr_addr  = a;
    wr_color = c;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_update();
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where busy has dropped.
  task automatic grab(input string tag, input logic [71:0] exp_bits);
    int hi, lo, nb, lead, bad_w, len, waitc;
    logic seen, to;
    logic [1:0] c;
    logic [71:0] bits;
    hi = 0; lo = 0; nb = 0; lead = 0; bad_w = 0; len = 0; waitc = 0;
    seen = 1'b0; to = 1'b0; bits = '0;
    while (busy !== 1'b1 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (busy !== 1'b1) to = 1'b1;
    while (busy === 1'b1 && len < 10000) begin
      len++;
      if (data === 1'b1) begin
        if (!seen) begin
          seen = 1'b1; lead = lo; lo = 0; hi = 1;
        end else if (lo > 0) begin
          c = classify(hi, lo);
          if (c[1]) bad_w++;
          bits = {bits[70:0], c[0]};
          nb++;
          hi = 1; lo = 0;
        end else begin
          hi++;
        end
      end else begin
        lo++;
      end
      @(negedge clk);
    end
    if (seen) begin
      c = classify(hi, lo - LATCH);
      if (c[1]) bad_w++;
      bits = {bits[70:0], c[0]};
      nb++;
    end
    check({tag, " timeout"}, 72'(to), 72'(0));
    check({tag, " bits"}, bits, exp_bits);
    check({tag, " nbits"}, 72'(nb), 72'(BITS));
    check({tag, " busy_len"}, 72'(len), 72'(FRAME));
    check({tag, " lead"}, 72'(lead), 72'(1));
    check({tag, " widths"}, 72'(bad_w), 72'(0));
    check({tag, " done"}, 72'(frame_done), 72'(1));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst data", 72'(data), 72'(0));
    check("rst busy", 72'(busy), 72'(0));
    check("rst done", 72'(frame_done), 72'(0));
    reset = 1'b0;

    // Power-up frame: LED0 rewritten mid-send keeps old value, LED2 takes new one.
    fork
      grab("f1", 72'h000000_000000_FFFFFF);
      begin
        repeat (50) @(negedge clk);
        wr(2'd0, 24'h123456);
        wr(2'd2, 24'hFFFFFF);
      end
    join
    grab("f2", 72'h341256_000000_FFFFFF);

    repeat (20) @(negedge clk);
    check("idle after f2", 72'(busy), 72'(0));
    wr(2'd3, 24'hABCDEF);
    repeat (20) @(negedge clk);
    check("out-of-range write", 72'(busy), 72'(0));

    // Second write lands in the frame-start cycle.
    wr(2'd1, 24'h00003C);
    wr(2'd0, 24'hA50000);
    grab("f3", 72'h341256_00003C_FFFFFF);
    grab("f4", 72'h00A500_00003C_FFFFFF);
    repeat (20) @(negedge clk);
    check("idle after f4", 72'(busy), 72'(0));
    check("done count 4", 72'(fd_cnt), 72'(4));

    pulse_update();
    fork
      grab("f5", 72'h00A500_00003C_FFFFFF);
      begin
        repeat (100) @(negedge clk);
        pulse_update();
        repeat (100) @(negedge clk);
        pulse_update();
      end
    join
    grab("f6", 72'h00A500_00003C_FFFFFF);
    repeat (20) @(negedge clk);
    check("idle after f6", 72'(busy), 72'(0));
    check("done count 6", 72'(fd_cnt), 72'(6));

    pulse_update();
    repeat (200) @(negedge clk);
    check("bit5 high", 72'(data), 72'(1));
    #1 reset = 1'b1;
    #1;
    check("async rst data", 72'(data), 72'(0));
    check("async rst busy", 72'(busy), 72'(0));
    repeat (3) @(negedge clk);
    check("rst hold done", 72'(frame_done), 72'(0));
    reset = 1'b0;
    grab("f7", 72'h00A500_00003C_FFFFFF);
    repeat (20) @(negedge clk);
    check("idle after f7", 72'(busy), 72'(0));
    check("done count 7", 72'(fd_cnt), 72'(7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws2812_chain.md
# ws2812_chain

Parametrised WS2812/WS2812B strip driver that streams a frame of NUM_LEDS 24-bit colours from an internal colour RAM onto a single data line. Successor to the single-LED status driver: supports arbitrary chain length, per-LED addressable colours, selectable channel order, explicit update handshake and optional auto-refresh on change. Sits between the core's LED/status register interface and the board's WS2812 pin.

## Interface
- CLK_FRE, 32_940_000, clock frequency in Hz
- NUM_LEDS, 8, LEDs in chain (≥1)
- T0H_NS, 400, high time of a 0 bit
- T0L_NS, 850, low time of a 0 bit
- T1H_NS, 850, high time of a 1 bit
- T1L_NS, 400, low time of a 1 bit
- RESET_US, 80, latch (low) time after each frame
- COLOR_ORDER, 0, 0 = transmit G,R,B; 1 = transmit R,G,B
- AUTO_REFRESH, 1, 1 = start a frame automatically when RAM is dirty
- ADDR_W, derived, clog2(max(NUM_LEDS,2))

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  colour RAM write strobe
- wr_addr  in  ADDR_W  LED index (0 = first LED on the wire)
- wr_color  in  24  colour {R[23:16],G[15:8],B[7:0]}
- update  in  1  single-cycle frame request
- busy  out  1  frame (including latch) in progress
- frame_done  out  1  one-cycle pulse at end of latch
- data  out  1  registered WS2812 serial output

## Operation
- Cycle counts: CLK_MHZ = CLK_FRE/1_000_000 (integer); CYC(ns) = max(1, CLK_MHZ*ns/1000) (integer division); latch = CLK_MHZ*RESET_US cycles.
- RAM: NUM_LEDS×24, write any cycle; wr_addr ≥ NUM_LEDS ignored (no dirty set). Reset does not clear RAM contents; read of unwritten entry is 0.
- dirty flag: set to 1 by reset and by every valid write; cleared in the cycle a frame starts, unless a valid write occurs that same cycle (then stays 1).
- pending flag: update sampled while busy sets pending (one-deep); cleared when next frame starts.
- States: IDLE, LOAD, HIGH, LOW, LATCH.
- IDLE: data=0. Start when update || pending || (AUTO_REFRESH && dirty) -> LOAD, LED index 0.
- LOAD: read RAM[index], reorder per COLOR_ORDER into 24-bit shift register, -> HIGH. Word is captured here; later writes to that LED affect the next frame only.
- HIGH: data=1 for CYC(T1H_NS) or CYC(T0H_NS) cycles per current bit (MSB first) -> LOW.
- LOW: data=0 for CYC(T1L_NS)/CYC(T0L_NS) cycles. Then: more bits -> HIGH; last bit, more LEDs -> next word (prefetched, no extra cycle) -> HIGH; last bit of last LED -> LATCH.
- LATCH: data=0 for latch cycles, then frame_done=1 one cycle, -> IDLE.
- update while IDLE and start condition true same cycle: single frame.

## Timing
- Reset values: data=0, busy=0, frame_done=0, state IDLE, counters 0, dirty=1, pending=0.
- Start sampled at edge N -> busy=1 and LOAD at N+1 -> data=1 from N+2.
- Bit period exactly CYC(H)+CYC(L) cycles; zero gap between bits and between LEDs (word prefetched during final LOW cycle of previous LED).
- Frame length = 1 + Σbits(CYC(H)+CYC(L)) + latch cycles; busy high throughout, falls with frame_done pulse in the same cycle.
- reset mid-frame: data drops to 0 immediately (async), state IDLE; with dirty=1 and AUTO_REFRESH a fresh frame starts after reset release.
- Bit counter 5 bits, LED counter ADDR_W bits, timing counter sized for latch count; no wrap within a frame.

## Structure
- Package ws2812_pkg: state enum, cyc_from_ns / cyc_from_us constant functions, COLOR_ORDER encodings.
- Sub-module ws2812_color_ram: synchronous write, one-cycle registered read, parametrised depth/width.
- Top: FSM, shift register, timing/bit/LED counters, dirty/pending flags.

## Test plan
- CLK_FRE=32_000_000, NUM_LEDS=1, write 0x00FF00 (green) -> after reset first frame: 8 bits of 27H/12L then 16 bits of 12H/27L; latch 2560 cycles; frame_done once.
- NUM_LEDS=3, COLOR_ORDER=1, write 0xA50000,0x00003C,0xFFFFFF, pulse update, AUTO_REFRESH=0 -> 72 bits R,G,B order, no gaps, busy exactly 1+72·39+2560 cycles.
- AUTO_REFRESH=1, idle, single write -> exactly one frame starts; write in same cycle as frame start -> second frame follows.
- update pulsed twice during busy -> exactly one extra frame after latch; frame_done pulses twice total.
- Write to LED 2 while LED 0 transmitting -> new value sent; write to LED 0 mid-transmission -> old value sent, new in next frame.
- Assert reset during HIGH of bit 5 -> data=0 same cycle, busy=0; wr_addr=NUM_LEDS write -> no frame, RAM unchanged.
